// File: rtl/mine_count_gen_if.sv
// Mine-count generator bus: control/map in from placement, count arrays and status out.
// The master side drives level/start/mine_arr; the slave (generator) drives the rest.
interface mine_count_gen_if;
    logic [1:0]              level;
    logic                    start;
    logic [15:0][15:0]       mine_arr;
    logic [7:0][7:0][2:0]    num_arr_easy;
    logic [9:0][9:0][2:0]    num_arr_medium;
    logic [15:0][15:0][2:0]  num_arr_hard;
    logic                    busy;
    logic                    done;

    modport master (
        output level, start, mine_arr,
        input  num_arr_easy, num_arr_medium, num_arr_hard, busy, done
    );

    modport slave (
        input  level, start, mine_arr,
        output num_arr_easy, num_arr_medium, num_arr_hard, busy, done
    );
endinterface

// File: rtl/mine_count_gen.sv
// Neighbour-mine count generator: latches a mine map on start and scans the selected board one
// cell per clock, writing a saturated 3-bit neighbour count (0 on mine cells) per cell.
module mine_count_gen #(
    parameter int unsigned SizeEasy   = 8,
    parameter int unsigned SizeMedium = 10,
    parameter int unsigned SizeHard   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mine_count_gen_if.slave       bus_io
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              x_q, x_d;
    logic [3:0]              y_q, y_d;
    logic [1:0]              lvl_q, lvl_d;
    logic [15:0][15:0]       map_q, map_d;
    logic [7:0][7:0][2:0]    easy_q, easy_d;
    logic [9:0][9:0][2:0]    med_q, med_d;
    logic [15:0][15:0][2:0]  hard_q, hard_d;

    logic [3:0]              max_idx;
    logic [2:0][3:0]         xs, ys;
    logic [2:0]              xv, yv;
    logic [3:0]              cnt;
    logic [2:0]              cell_val;

    always_comb begin
        case (lvl_q)
            2'd1:    max_idx = 4'(SizeEasy - 1);
            2'd2:    max_idx = 4'(SizeMedium - 1);
            default: max_idx = 4'(SizeHard - 1);
        endcase
    end

    // Neighbour coordinates may wrap in 4 bits; the valid flags drop those at the board edges.
    always_comb begin
        xs[0] = x_q - 4'd1;
        xs[1] = x_q;
        xs[2] = x_q + 4'd1;
        ys[0] = y_q - 4'd1;
        ys[1] = y_q;
        ys[2] = y_q + 4'd1;
        xv    = {x_q != max_idx, 1'b1, x_q != 4'd0};
        yv    = {y_q != max_idx, 1'b1, y_q != 4'd0};
        cnt   = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (!(i == 1 && j == 1)) begin
                    cnt = cnt + {3'b000, map_q[xs[i]][ys[j]] & xv[i] & yv[j]};
                end
            end
        end
        if (map_q[x_q][y_q]) begin
            cell_val = 3'd0;
        end else if (cnt[3]) begin
            cell_val = 3'd7;
        end else begin
            cell_val = cnt[2:0];
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        lvl_d   = lvl_q;
        map_d   = map_q;
        easy_d  = easy_q;
        med_d   = med_q;
        hard_d  = hard_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start && bus_io.level != 2'd0) begin
                    lvl_d   = bus_io.level;
                    map_d   = bus_io.mine_arr;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                case (lvl_q)
                    2'd1:    easy_d[x_q[2:0]][y_q[2:0]] = cell_val;
                    2'd2:    med_d[x_q][y_q] = cell_val;
                    2'd3:    hard_d[x_q][y_q] = cell_val;
                    default: ;
                endcase
                if (x_q == max_idx) begin
                    x_d = '0;
                    if (y_q == max_idx) begin
                        state_d = StDone;
                    end else begin
                        y_d = y_q + 4'd1;
                    end
                end else begin
                    x_d = x_q + 4'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            lvl_q   <= '0;
            map_q   <= '0;
            easy_q  <= '0;
            med_q   <= '0;
            hard_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lvl_q   <= lvl_d;
            map_q   <= map_d;
            easy_q  <= easy_d;
            med_q   <= med_d;
            hard_q  <= hard_d;
        end
    end

    assign bus_io.num_arr_easy   = easy_q;
    assign bus_io.num_arr_medium = med_q;
    assign bus_io.num_arr_hard   = hard_q;
    assign bus_io.busy           = (state_q == StScan);
    assign bus_io.done           = (state_q == StDone);

endmodule

// File: tb/tb_mine_count_gen.sv
// Bench for mine_count_gen: directed and random scans checked every cycle against a
// board-level model that recomputes neighbour counts directly from the latched map.
module tb_mine_count_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mine_count_gen_if bus ();

    mine_count_gen dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: 0 idle, 1 scanning, 2 done pulse.
    int                      m_phase = 0;
    int                      m_left = 0;
    int                      m_n = 8;
    logic [1:0]              m_lvl = '0;
    logic [15:0][15:0]       m_map = '0;
    logic [15:0][15:0][2:0]  m_easy = '0;
    logic [15:0][15:0][2:0]  m_med = '0;
    logic [15:0][15:0][2:0]  m_hard = '0;

    function automatic int size_of(input logic [1:0] l);
        case (l)
            2'd1:    return 8;
            2'd2:    return 10;
            default: return 16;
        endcase
    endfunction

    function automatic logic [15:0][15:0][2:0] expect_counts(input logic [15:0][15:0] map,
                                                             input int n);
        logic [15:0][15:0][2:0] res;
        int cnt;
        res = '0;
        for (int x = 0; x < n; x++) begin
            for (int y = 0; y < n; y++) begin
                cnt = 0;
                for (int dx = -1; dx <= 1; dx++) begin
                    for (int dy = -1; dy <= 1; dy++) begin
                        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < n &&
                            y + dy >= 0 && y + dy < n && map[x + dx][y + dy]) begin
                            cnt++;
                        end
                    end
                end
                if (map[x][y]) res[x][y] = 3'd0;
                else if (cnt > 7) res[x][y] = 3'd7;
                else res[x][y] = 3'(cnt);
            end
        end
        return res;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_easy  <= '0;
            m_med   <= '0;
            m_hard  <= '0;
        end else begin
            case (m_phase)
                0: if (bus.start && bus.level != 2'd0) begin
                    m_lvl   <= bus.level;
                    m_map   <= bus.mine_arr;
                    m_n     <= size_of(bus.level);
                    m_left  <= size_of(bus.level) * size_of(bus.level);
                    m_phase <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        case (m_lvl)
                            2'd1:    m_easy <= expect_counts(m_map, m_n);
                            2'd2:    m_med  <= expect_counts(m_map, m_n);
                            default: m_hard <= expect_counts(m_map, m_n);
                        endcase
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_cells(input string name, input int n,
                               input logic [15:0][15:0][2:0] act,
                               input logic [15:0][15:0][2:0] exp);
        bit bad = 0;
        int bx = 0, by = 0;
        for (int x = 0; x < n; x++) begin
            for (int y = 0; y < n; y++) begin
                if (!bad && act[x][y] !== exp[x][y]) begin
                    bad = 1;
                    bx  = x;
                    by  = y;
                end
            end
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s cell (%0d,%0d) at %0t: got %0d, want %0d", name, bx, by, $time,
                     act[bx][by], exp[bx][by]);
        end
    endtask

    // Per-cycle compare: status always, arrays whenever no scan is in progress.
    initial begin
        logic [15:0][15:0][2:0] ae, am, ah;
        forever begin
            @(negedge clk);
            vectors++;
            if (bus.busy !== (m_phase == 1)) begin
                miscompares++;
                $display("FAIL busy at %0t: got %b, want %0d", $time, bus.busy, m_phase == 1);
            end
            vectors++;
            if (bus.done !== (m_phase == 2)) begin
                miscompares++;
                $display("FAIL done at %0t: got %b, want %0d", $time, bus.done, m_phase == 2);
            end
            if (m_phase != 1) begin
                ae = '0;
                am = '0;
                ah = bus.num_arr_hard;
                for (int x = 0; x < 8; x++)
                    for (int y = 0; y < 8; y++) ae[x][y] = bus.num_arr_easy[x][y];
                for (int x = 0; x < 10; x++)
                    for (int y = 0; y < 10; y++) am[x][y] = bus.num_arr_medium[x][y];
                check_cells("easy_array", 8, ae, m_easy);
                check_cells("medium_array", 10, am, m_med);
                check_cells("hard_array", 16, ah, m_hard);
            end
        end
    end

    // Start a scan and follow it to done; optionally disturb inputs or reset mid-scan.
    task automatic run_scan(input logic [1:0] lvl, input logic [15:0][15:0] map,
                            input int disturb_at, input int reset_at,
                            output int busy_cycles, output int dones);
        @(negedge clk);
        bus.level    = lvl;
        bus.mine_arr = map;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        busy_cycles = 0;
        dones       = 0;
        for (int c = 0; c < 400; c++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                dones++;
                break;
            end
            if (c == reset_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("busy_after_reset", int'(bus.busy), 0);
                check("hard_cleared_on_reset", int'(bus.num_arr_hard == '0), 1);
                return;
            end
            if (c == disturb_at) begin
                bus.mine_arr = ~bus.mine_arr;
                bus.level    = 2'd1;
                bus.start    = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (dones == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scan_timeout: got no done, want done within 400 cycles");
        end
    endtask

    function automatic logic [15:0][15:0] rand_map(input int dens);
        logic [15:0][15:0] m;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) m[x][y] = ($urandom_range(0, 99) < dens);
        return m;
    endfunction

    initial begin
        logic [15:0][15:0] map;
        int bc, dn;
        bus.level    = 2'd0;
        bus.start    = 1'b0;
        bus.mine_arr = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset state and ignored level-0 start
        @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_easy_zero", int'(bus.num_arr_easy == '0), 1);
        check("reset_hard_zero", int'(bus.num_arr_hard == '0), 1);
        bus.level = 2'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("level0_no_busy", int'(bus.busy), 0);
            check("level0_no_done", int'(bus.done), 0);
            @(negedge clk);
        end

        // Single mine at (3,3) on easy
        map = '0;
        map[3][3] = 1'b1;
        run_scan(2'd1, map, -1, -1, bc, dn);
        check("easy_busy_cycles", bc, 64);
        check("easy_done_count", dn, 1);
        check("easy_2_2", int'(bus.num_arr_easy[2][2]), 1);
        check("easy_4_3", int'(bus.num_arr_easy[4][3]), 1);
        check("easy_3_3_mine", int'(bus.num_arr_easy[3][3]), 0);
        check("easy_5_5", int'(bus.num_arr_easy[5][5]), 0);
        check("model_easy_2_4", int'(m_easy[2][4]), 1);
        check("medium_untouched", int'(bus.num_arr_medium == '0), 1);

        // Corner cluster on easy, back-to-back with the previous done
        map = '0;
        map[0][0] = 1'b1;
        map[1][0] = 1'b1;
        map[0][1] = 1'b1;
        run_scan(2'd1, map, -1, -1, bc, dn);
        check("corner_1_1", int'(bus.num_arr_easy[1][1]), 3);
        check("corner_2_0", int'(bus.num_arr_easy[2][0]), 1);
        check("corner_0_0", int'(bus.num_arr_easy[0][0]), 0);
        check("corner_7_7", int'(bus.num_arr_easy[7][7]), 0);
        check("corner_7_0_nowrap", int'(bus.num_arr_easy[7][0]), 0);
        check("corner_0_7_nowrap", int'(bus.num_arr_easy[0][7]), 0);
        check("model_corner_1_1", int'(m_easy[1][1]), 3);

        // Saturation on hard
        map = '0;
        for (int dx = -1; dx <= 1; dx++)
            for (int dy = -1; dy <= 1; dy++)
                if (dx != 0 || dy != 0) map[5 + dx][5 + dy] = 1'b1;
        run_scan(2'd3, map, -1, -1, bc, dn);
        check("hard_busy_cycles", bc, 256);
        check("hard_5_5_saturated", int'(bus.num_arr_hard[5][5]), 7);
        check("hard_4_4_mine", int'(bus.num_arr_hard[4][4]), 0);
        check("model_hard_5_5", int'(m_hard[5][5]), 7);

        // Off-board mine on medium with a disturbed scan
        map = '0;
        map[12][4] = 1'b1;
        run_scan(2'd2, map, 40, -1, bc, dn);
        check("medium_busy_cycles", bc, 100);
        check("medium_done_count", dn, 1);
        check("medium_9_4", int'(bus.num_arr_medium[9][4]), 0);
        @(negedge clk);
        check("medium_done_one_cycle", int'(bus.done), 0);

        // Reset in the middle of a hard scan, then a fresh scan
        map = rand_map(30);
        run_scan(2'd3, map, -1, 50, bc, dn);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_scan(2'd3, map, -1, -1, bc, dn);
        check("post_reset_busy_cycles", bc, 256);
        check("post_reset_done_count", dn, 1);

        // Random boards of varied density and level
        for (int t = 0; t < 8; t++) begin
            logic [1:0] lvl;
            lvl = 2'($urandom_range(1, 3));
            map = rand_map($urandom_range(5, 95));
            run_scan(lvl, map, (t % 2 == 0) ? int'($urandom_range(0, 60)) : -1, -1, bc, dn);
            check("rand_busy_cycles", bc, size_of(lvl) * size_of(lvl));
            check("rand_done_count", dn, 1);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
